// File: rtl/alu_iterative_divider.sv
// ---------------------------------------------------------------------------
// alu_iterative_divider
//   32-bit RV32M divide/remainder unit (DIV, DIVU, REM, REMU) built around a
//   radix-2 restoring divider that retires one quotient bit per clock.
//   Signed operations divide operand magnitudes and fix the sign at the end.
//   Divide-by-zero and the signed overflow case bypass the iteration and
//   complete on the cycle after the start edge.
//
// Ports
//   i_clk     in   1   clock, rising edge
//   i_rst_n   in   1   asynchronous active-low reset
//   i_start   in   1   request, honoured only in IDLE or DONE
//   i_op      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a       in  32   dividend (rs1)
//   i_b       in  32   divisor  (rs2)
//   o_busy    out  1   high while iterating (CALC) or sign-fixing (FIX)
//   o_valid   out  1   one-cycle completion pulse (DONE)
//   o_result  out 32   quotient or remainder, held until the next result
//
// Also contains alu_carry_lookahead_subtractor, the single subtractor used
// by the iteration step.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu_carry_lookahead_subtractor
//   diff = a - b computed as a + ~b + 1 with 4-bit carry-lookahead groups
//   chained group to group.
//   a, b       in  32   operands
//   diff       out 32   a - b modulo 2^32
//   carry_out  out  1   1 when a >= b (no borrow)
// ---------------------------------------------------------------------------
module alu_carry_lookahead_subtractor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        carry_out
);
    logic [31:0] gen;
    logic [31:0] prop;
    logic [32:0] carry;

    assign gen  = a & ~b;
    assign prop = a ^ ~b;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        carry    = '0;
        carry[0] = 1'b1;   // the +1 of the two's-complement subtraction
        for (int grp = 0; grp < 8; grp++) begin
            carry[4*grp+1] = gen[4*grp]
                           | (prop[4*grp] & carry[4*grp]);
            carry[4*grp+2] = gen[4*grp+1]
                           | (prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
            carry[4*grp+3] = gen[4*grp+2]
                           | (prop[4*grp+2] & gen[4*grp+1])
                           | (prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
            carry[4*grp+4] = gen[4*grp+3]
                           | (prop[4*grp+3] & gen[4*grp+2])
                           | (prop[4*grp+3] & prop[4*grp+2] & gen[4*grp+1])
                           | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & prop[4*grp]
                              & carry[4*grp]);
        end
    end

    assign diff      = prop ^ carry[31:0];
    assign carry_out = carry[32];
endmodule

module alu_iterative_divider (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Captured operation context
    logic [1:0]  op_q;
    logic [31:0] dividend_q;   // magnitude; shifts out MSB-first, quotient bits shift in
    logic [31:0] divisor_q;    // magnitude
    logic [31:0] rem_q;        // partial remainder
    logic [5:0]  count_q;
    logic        quot_neg_q;
    logic        rem_neg_q;

    // ---------------- request decode ----------------
    logic        accept;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] special_result;

    assign accept    = i_start && (state == S_IDLE || state == S_DONE);
    assign is_signed = ~i_op[0];
    assign a_neg     = is_signed & i_a[31];
    assign b_neg     = is_signed & i_b[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign a_mag     = a_neg ? (~i_a + 32'd1) : i_a;
    assign b_mag     = b_neg ? (~i_b + 32'd1) : i_b;
    assign div_zero  = (i_b == 32'd0);
    assign overflow  = is_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign special   = div_zero | overflow;

    always_comb begin
        special_result = 32'd0;
        if (div_zero) begin
            special_result = i_op[1] ? i_a : 32'hFFFF_FFFF;
        end else begin
            special_result = i_op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // ---------------- one restoring step ----------------
    // The shifted remainder is 33 bits wide; when its top bit is set it is
    // certainly >= the divisor and the low 32 bits of the difference are
    // still exact modulo 2^32.
    logic [32:0] shifted;
    logic [31:0] step_diff;
    logic        step_no_borrow;
    logic        step_ge;

    assign shifted = {rem_q, dividend_q[31]};

    alu_carry_lookahead_subtractor u_sub (
        .a         (shifted[31:0]),
        .b         (divisor_q),
        .diff      (step_diff),
        .carry_out (step_no_borrow)
    );

    assign step_ge = shifted[32] | step_no_borrow;

    // ---------------- sign fix ----------------
    logic [31:0] fix_sel;
    logic        fix_neg;
    logic [31:0] fix_result;

    assign fix_sel    = op_q[1] ? rem_q : dividend_q;
    assign fix_neg    = op_q[1] ? rem_neg_q : quot_neg_q;
    assign fix_result = fix_neg ? (~fix_sel + 32'd1) : fix_sel;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        o_valid    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                o_valid = (state == S_DONE);
                if (accept) begin
                    state_next = special ? S_DONE : S_CALC;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CALC: begin
                o_busy = 1'b1;
                if (count_q == 6'd31) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                o_busy     = 1'b1;
                state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: every datapath register is cleared by reset so an aborted
        // operation leaves nothing behind for the next request.
        if (!i_rst_n) begin
            op_q       <= 2'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            rem_q      <= 32'd0;
            count_q    <= 6'd0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            o_result   <= 32'd0;
        end else if (accept) begin
            op_q       <= i_op;
            dividend_q <= a_mag;
            divisor_q  <= b_mag;
            rem_q      <= 32'd0;
            count_q    <= 6'd0;
            quot_neg_q <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            if (special) begin
                o_result <= special_result;
            end
        end else if (state == S_CALC) begin
            rem_q      <= step_ge ? step_diff : shifted[31:0];
            dividend_q <= {dividend_q[30:0], step_ge};
            count_q    <= count_q + 6'd1;
        end else if (state == S_FIX) begin
            o_result   <= fix_result;
        end
    end
endmodule

// File: tb/tb_alu_iterative_divider.sv
// ---------------------------------------------------------------------------
// tb_alu_iterative_divider
//   Scoreboard bench: the driver pushes the expected result, completion cycle
//   and busy-cycle count for each accepted request; a monitor pops and
//   compares on every o_valid pulse.
// ---------------------------------------------------------------------------
module tb_alu_iterative_divider;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          busy;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_run = 0;
    exp_t sb[$];

    alu_iterative_divider dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: RV32M division semantics from plain arithmetic.
    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sbv;
        sa  = a;
        sbv = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            OP_DIV:  return sa / sbv;
            OP_REM:  return sa % sbv;
            OP_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    // Monitor: pops one expectation per o_valid pulse.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            busy_run = 0;
        end else if (o_valid) begin
            check("valid_was_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("result", o_result, e.res);
                check("valid_cycle", cyc, e.cyc);
                check("busy_cycles", busy_run, e.busy);
            end
            busy_run = 0;
        end else if (o_busy) begin
            busy_run++;
        end
    end

    // Called at a negedge; the request is sampled on the following posedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   sp;
        sp     = is_special(op, a, b);
        e.res  = model(op, a, b);
        e.cyc  = cyc + 1 + (sp ? 0 : 33);
        e.busy = sp ? 0 : 33;
        sb.push_back(e);
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        // Scramble the operand bus; the captured operation must not notice.
        i_op    = 2'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("idle_within_bound", (n < 100), 1'b1);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_idle();
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_op    = 2'd0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        #1;
        check("reset_busy",   o_busy,   1'b0);
        check("reset_valid",  o_valid,  1'b0);
        check("reset_result", o_result, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Start on the very first edge after reset release.
        run(OP_DIVU, 32'd100, 32'd7);
        run(OP_REMU, 32'd100, 32'd7);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run(OP_REM, 32'hFFFF_FFF9, 32'd2);
        run(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        run(OP_REM, 32'd7, 32'hFFFF_FFFE);
        run(OP_DIVU, 32'h1234, 32'd0);
        run(OP_REMU, 32'd5, 32'd0);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        // Back-to-back: the second start lands in the DONE cycle of the first.
        run(OP_DIVU, 32'd50, 32'd5);
        run(OP_REMU, 32'd50, 32'd7);

        // A start while busy must be ignored.
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        repeat (9) @(negedge i_clk);
        i_op = OP_REMU; i_a = 32'd77; i_b = 32'd3; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_idle();
        repeat (3) @(negedge i_clk);

        // Asynchronous reset in the middle of CALC.
        issue(OP_DIVU, 32'd1000, 32'd7);
        repeat (14) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy",   o_busy,   1'b0);
        check("abort_valid",  o_valid,  1'b0);
        check("abort_result", o_result, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run(OP_DIVU, 32'd9, 32'd3);

        // Randomized traffic with occasional idle gaps.
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run(op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge i_clk);
                n++;
            end
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (5) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
